// File: rtl/progmem_boot_streamer.sv
`default_nettype none
// ============================================================================
// Module   : progmem_boot_streamer
// Purpose  : Buffers a boot image from a slow byte source while holding the
//            core in reset, then replays it as a gap-free burst on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module progmem_boot_streamer #(
    parameter int ADDR_W = 12,
    parameter int BYTES  = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_src_valid,
    input  logic [7:0]        i_src_data,
    output logic              o_src_ready,
    output logic              o_core_n_reset,
    output logic [7:0]        o_data,
    output logic              o_data_oe,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_count
);

    localparam int              C_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_LAST  = (ADDR_W + 1)'(BYTES - 1);
    localparam logic [ADDR_W:0] C_BYTES = (ADDR_W + 1)'(BYTES);
    localparam logic [ADDR_W:0] C_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_BURST = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]        r_mem [0:C_DEPTH-1];
    logic [7:0]        r_rd_data;

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_data;
    logic              r_src_ready;
    logic              r_core_n_reset;
    logic              r_data_oe;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic [7:0]        w_data_nxt;
    logic              w_src_ready_nxt;
    logic              w_core_n_reset_nxt;
    logic              w_data_oe_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic              w_accept;
    logic              w_last_accept;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_accept      = (r_state == ST_LOAD) && i_src_valid;
    assign w_last_accept = w_accept && (r_wr_ptr == C_LAST);
    assign w_wr_addr     = r_wr_ptr[ADDR_W-1:0];
    // Address 0 is fetched on the last-accept edge so the first burst byte
    // is already in the read register when GAP ends.
    assign w_rd_addr     = w_last_accept ? '0 : r_rd_ptr[ADDR_W-1:0];

    // Image RAM: contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[w_wr_addr] <= i_src_data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_data_nxt   = r_data;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_wr_ptr_nxt = '0;
                    w_rd_ptr_nxt = '0;
                    w_count_nxt  = '0;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_wr_ptr_nxt = r_wr_ptr + C_ONE;
                    w_count_nxt  = r_count + C_ONE;
                    if (w_last_accept) begin
                        w_state_nxt  = ST_GAP;
                        w_rd_ptr_nxt = C_ONE;
                        w_count_nxt  = '0;
                    end
                end
            end
            ST_GAP: begin
                w_state_nxt  = ST_BURST;
                w_data_nxt   = r_rd_data;
                w_count_nxt  = C_ONE;
                w_rd_ptr_nxt = r_rd_ptr + C_ONE;
            end
            ST_BURST: begin
                if (r_count == C_BYTES) begin
                    w_state_nxt = ST_DONE;
                    w_data_nxt  = '0;
                end else begin
                    w_data_nxt   = r_rd_data;
                    w_rd_ptr_nxt = r_rd_ptr + C_ONE;
                    w_count_nxt  = r_count + C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Flags are decoded from the next state so they register in step with it.
        w_src_ready_nxt    = (w_state_nxt == ST_LOAD);
        w_core_n_reset_nxt = (w_state_nxt == ST_GAP) || (w_state_nxt == ST_BURST) ||
                             (w_state_nxt == ST_DONE);
        w_data_oe_nxt      = (w_state_nxt == ST_BURST);
        w_busy_nxt         = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_GAP) ||
                             (w_state_nxt == ST_BURST);
        w_done_nxt         = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_data         <= '0;
            r_src_ready    <= 1'b0;
            r_core_n_reset <= 1'b0;
            r_data_oe      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_data         <= w_data_nxt;
            r_src_ready    <= w_src_ready_nxt;
            r_core_n_reset <= w_core_n_reset_nxt;
            r_data_oe      <= w_data_oe_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
        end
    end

    assign o_src_ready    = r_src_ready;
    assign o_core_n_reset = r_core_n_reset;
    assign o_data         = r_data;
    assign o_data_oe      = r_data_oe;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_progmem_boot_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_progmem_boot_streamer
// Purpose  : Directed bench for progmem_boot_streamer with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_progmem_boot_streamer;

    localparam int AW = 3;
    localparam int NB = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [7:0]    sdata = 8'h00;
    logic          src_ready;
    logic          core_n_reset;
    logic [7:0]    data;
    logic          data_oe;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    progmem_boot_streamer #(
        .ADDR_W (AW),
        .BYTES  (NB)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_src_valid    (valid),
        .i_src_data     (sdata),
        .o_src_ready    (src_ready),
        .o_core_n_reset (core_n_reset),
        .o_data         (data),
        .o_data_oe      (data_oe),
        .o_busy         (busy),
        .o_done         (done),
        .o_count        (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 after last accept (m_t edges since it).
    int         m_phase = 0;
    int         m_acc   = 0;
    int         m_t     = 0;
    logic [7:0] m_img [NB];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_acc   = 0;
            m_t     = 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_acc = 0; end
                1: if (valid) begin
                    m_img[m_acc] = sdata;
                    m_acc++;
                    if (m_acc == NB) begin m_phase = 2; m_t = 0; end
                end
                default: begin
                    if (m_t > NB && start) begin
                        m_phase = 1;
                        m_acc   = 0;
                    end else if (m_t <= NB) begin
                        m_t++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic       e_oe;
        logic [7:0] e_data;
        int         e_count;
        e_oe    = (m_phase == 2) && (m_t >= 1) && (m_t <= NB);
        e_data  = e_oe ? m_img[m_t-1] : 8'h00;
        e_count = (m_phase == 1) ? m_acc : ((m_phase == 2) ? ((m_t > NB) ? NB : m_t) : 0);
        chk("m_src_ready", src_ready, m_phase == 1);
        chk("m_core_n_reset", core_n_reset, m_phase == 2);
        chk("m_data_oe", data_oe, e_oe);
        chk("m_data", data, e_data);
        chk("m_busy", busy, (m_phase == 1) || (m_phase == 2 && m_t <= NB));
        chk("m_done", done, (m_phase == 2) && (m_t > NB));
        chk("m_count", count, e_count);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams NB bytes from base; stalls idle cycles between bytes; poke adds
    // start pulses on byte 2 and on the last accept.
    task automatic send(input logic [7:0] base, input int stalls, input bit poke);
        for (int i = 0; i < NB; i++) begin
            valid = 1'b1;
            sdata = base + i[7:0];
            if (poke && (i == 2 || i == NB - 1)) start = 1'b1;
            tick();
            start = 1'b0;
            valid = 1'b0;
            if (i < NB - 1) repeat (stalls) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_nrst", core_n_reset, 0);
        chk("rst_count", count, 0);
        chk("rst_oe", data_oe, 0);
        #2 rst = 1'b0;
        tick();

        // Nominal load
        pulse_start();
        chk("s1_ready", src_ready, 1);
        send(8'h10, 0, 1'b0);
        chk("s1_gap_nrst", core_n_reset, 1);
        chk("s1_gap_oe", data_oe, 0);
        tick();
        chk("s1_byte0", data, 8'h10);
        chk("s1_byte0_oe", data_oe, 1);
        repeat (3) tick();
        chk("s1_byte3", data, 8'h13);
        repeat (5) tick();
        chk("s1_done", done, 1);
        chk("s1_count", count, 8);
        chk("s1_done_oe", data_oe, 0);

        // Source valid while DONE is not accepted
        valid = 1'b1;
        sdata = 8'hEE;
        tick();
        chk("s5_done_ready", src_ready, 0);
        valid = 1'b0;
        tick();

        // Stalled load, restarting from DONE
        pulse_start();
        chk("s2_restart_nrst", core_n_reset, 0);
        chk("s2_count_clr", count, 0);
        send(8'hA0, 2, 1'b0);
        chk("s2_gap_count", count, 0);
        repeat (10) tick();
        chk("s2_done", done, 1);

        // Start pulses during LOAD, GAP and BURST are ignored
        pulse_start();
        send(8'hF0, 0, 1'b1);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("s5_byte1", data, 8'hF1);
        repeat (8) tick();
        chk("s5_done", done, 1);
        chk("s5_count", count, 8);

        // Reset mid-LOAD
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            sdata = 8'h30 + i[7:0];
            tick();
        end
        valid = 1'b0;
        chk("s3_count3", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("s3_async_ready", src_ready, 0);
        chk("s3_async_count", count, 0);
        chk("s3_async_busy", busy, 0);
        tick();
        #2 rst = 1'b0;
        valid = 1'b1;
        sdata = 8'h99;
        tick();
        chk("s5_idle_ready", src_ready, 0);
        valid = 1'b0;
        pulse_start();
        send(8'h55, 0, 1'b0);
        tick();
        chk("s3_byte0", data, 8'h55);
        repeat (7) tick();
        chk("s3_byte7", data, 8'h5C);
        tick();
        chk("s3_done", done, 1);

        // Reset mid-BURST
        pulse_start();
        send(8'hC0, 0, 1'b0);
        repeat (4) tick();
        chk("s4_byte3", data, 8'hC3);
        #2 rst = 1'b1;
        #1;
        chk("s4_async_oe", data_oe, 0);
        chk("s4_async_nrst", core_n_reset, 0);
        chk("s4_async_data", data, 0);
        repeat (3) tick();
        #2 rst = 1'b0;
        repeat (4) tick();
        chk("s4_idle_oe", data_oe, 0);
        chk("s4_idle_nrst", core_n_reset, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
